mem_access_unit: RTL

Memory-access stage of the MINA2000 pipeline. It consumes the `mem_params_t` bundle the execute stage latches into EX/MEM and performs the load or store over a single-outstanding valid/ready data bus. Results go out as registered writeback signals toward MEM/WB. While a bus transaction is in flight, `stall` freezes every stage up to and including EX/MEM.

---
 rtl/mem_access_unit.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MINA2000 memory-access stage: one outstanding load/store on a valid/ready bus, registered writeback.
// Optional build macro MEM_ALIGN_CHECK_EN turns misaligned half/word accesses into a misalign fault.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_valid,
    input  logic [4:0]        i_mem_rd_addr,
    input  logic [31:0]       i_mem_rd_data,
    input  logic [3:0]        i_mem_op,
    input  logic [31:0]       i_mem_data,
    output logic              o_stall,
    output logic              o_bus_req_valid,
    input  logic              i_bus_req_ready,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic              o_bus_we,
    output logic [3:0]        o_bus_be,
    output logic [31:0]       o_bus_wdata,
    input  logic              i_bus_rsp_valid,
    input  logic [31:0]       i_bus_rsp_rdata,
    output logic              o_wb_valid,
    output logic              o_wb_we,
    output logic [4:0]        o_wb_rd_addr,
    output logic [31:0]       o_wb_rd_data
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              o_misalign
`endif
);

    localparam logic [3:0] MEM_OP_NONE = 4'd0;
    localparam logic [3:0] MEM_OP_LB   = 4'd1;
    localparam logic [3:0] MEM_OP_LBU  = 4'd2;
    localparam logic [3:0] MEM_OP_LH   = 4'd3;
    localparam logic [3:0] MEM_OP_LHU  = 4'd4;
    localparam logic [3:0] MEM_OP_LW   = 4'd5;
    localparam logic [3:0] MEM_OP_SB   = 4'd6;
    localparam logic [3:0] MEM_OP_SH   = 4'd7;
    localparam logic [3:0] MEM_OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic              w_stall;
    logic              w_accept;
    logic              w_pass;
    logic              w_fault;
    logic              w_done;
    logic              w_is_mem;
    logic              w_misaligned;
    logic [1:0]        w_a;

    logic [3:0]        r_op;
    logic [1:0]        r_a;
    logic [4:0]        r_rd_addr;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_bus_addr;
    logic              r_bus_we;
    logic [3:0]        r_bus_be;
    logic [31:0]       r_bus_wdata;
    logic              r_wb_valid;
    logic              r_wb_we;
    logic [4:0]        r_wb_rd_addr;
    logic [31:0]       r_wb_rd_data;
`ifdef MEM_ALIGN_CHECK_EN
    logic              r_misalign;
`endif

    function automatic logic is_load(input logic [3:0] op);
        return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
    endfunction

    function automatic logic is_byte(input logic [3:0] op);
        return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_SB);
    endfunction

    function automatic logic is_half(input logic [3:0] op);
        return (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return (op == MEM_OP_LW) || (op == MEM_OP_SW);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
        return (is_half(op) && a[0]) || (is_word(op) && (a != 2'b00));
    endfunction

    // Half enables only look at a[1], so an odd half address is truncated for free.
    function automatic logic [3:0] lane_be(input logic [3:0] op, input logic [1:0] a);
        logic [3:0] be;
        if (is_byte(op)) begin
            be = 4'b0001 << a;
        end else if (is_half(op)) begin
            be = 4'b0011 << {a[1], 1'b0};
        end else begin
            be = 4'hF;
        end
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [3:0] op, input logic [31:0] d);
        logic [31:0] wd;
        if (is_byte(op)) begin
            wd = {4{d[7:0]}};
        end else if (is_half(op)) begin
            wd = {2{d[15:0]}};
        end else begin
            wd = d;
        end
        return wd;
    endfunction

    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] a,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (a)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            2'd3:    b = rdata[31:24];
            default: b = 8'd0;
        endcase
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            MEM_OP_LB:  res = {{24{b[7]}}, b};
            MEM_OP_LBU: res = {24'd0, b};
            MEM_OP_LH:  res = {{16{h[15]}}, h};
            MEM_OP_LHU: res = {16'd0, h};
            default:    res = rdata;
        endcase
        return res;
    endfunction

    assign w_a      = i_mem_rd_data[1:0];
    assign w_is_mem = is_load(i_mem_op) || is_store(i_mem_op);
`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = misaligned(i_mem_op, w_a);
`else
    assign w_misaligned = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, stall and datapath strobes
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_accept     = 1'b0;
        w_pass       = 1'b0;
        w_fault      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_mem_valid) begin
                    if (!w_is_mem) begin
                        w_pass = 1'b1;
                    end else if (w_misaligned) begin
                        w_fault = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_stall      = 1'b1;
                        w_next_state = ST_REQ;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_REQ: begin
                w_stall = 1'b1;
                if (i_bus_req_ready) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (i_bus_rsp_valid) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Bus request registers and writeback registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op         <= 4'd0;
            r_a          <= 2'd0;
            r_rd_addr    <= 5'd0;
            r_req_valid  <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_we     <= 1'b0;
            r_bus_be     <= 4'd0;
            r_bus_wdata  <= 32'd0;
            r_wb_valid   <= 1'b0;
            r_wb_we      <= 1'b0;
            r_wb_rd_addr <= 5'd0;
            r_wb_rd_data <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
            r_misalign   <= 1'b0;
`endif
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
            if (w_pass) begin
                r_wb_valid   <= 1'b1;
                r_wb_we      <= 1'b1;
                r_wb_rd_addr <= i_mem_rd_addr;
                r_wb_rd_data <= i_mem_rd_data;
            end else if (w_fault) begin
                r_wb_valid   <= 1'b1;
                r_wb_rd_addr <= i_mem_rd_addr;
                r_wb_rd_data <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
                r_misalign   <= 1'b1;
`endif
            end else if (w_done) begin
                r_wb_valid   <= 1'b1;
                r_wb_we      <= is_load(r_op);
                r_wb_rd_addr <= r_rd_addr;
                r_wb_rd_data <= is_load(r_op) ? load_extract(r_op, r_a, i_bus_rsp_rdata) : 32'd0;
            end

            if (w_accept) begin
                r_op        <= i_mem_op;
                r_a         <= w_a;
                r_rd_addr   <= i_mem_rd_addr;
                r_req_valid <= 1'b1;
                r_bus_addr  <= {i_mem_rd_data[ADDR_W-1:2], 2'b00};
                r_bus_we    <= is_store(i_mem_op);
                r_bus_be    <= lane_be(i_mem_op, w_a);
                r_bus_wdata <= lane_wdata(i_mem_op, i_mem_data);
            end else if ((r_state == ST_REQ) && i_bus_req_ready) begin
                r_req_valid <= 1'b0;
            end
        end
    end

    assign o_stall         = w_stall;
    assign o_bus_req_valid = r_req_valid;
    assign o_bus_addr      = r_bus_addr;
    assign o_bus_we        = r_bus_we;
    assign o_bus_be        = r_bus_be;
    assign o_bus_wdata     = r_bus_wdata;
    assign o_wb_valid      = r_wb_valid;
    assign o_wb_we         = r_wb_we;
    assign o_wb_rd_addr    = r_wb_rd_addr;
    assign o_wb_rd_data    = r_wb_rd_data;
`ifdef MEM_ALIGN_CHECK_EN
    assign o_misalign      = r_misalign;
`endif

endmodule
